// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM serial load/unload paths: default geometry,
// the transmit FSM state encoding and the even-parity helper.
package sram_pkg;

  localparam int DEF_ROWS = 16;
  localparam int DEF_COLS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_SHIFT,
    ST_DONE
  } tx_state_t;

  // Callers zero-extend their word; extra zero bits leave the parity unchanged.
  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/sram_serial_tx_if.sv
// Signal bundle between sram_serial_tx (master), the SRAM read port and the serial pins.
interface sram_serial_tx_if
  import sram_pkg::*;
#(
  parameter int AW   = 4,
  parameter int COLS = 8
) ();

  // Handshakes: start is a level sampled only while idle; sram_r_en and
  // sram_data_valid are single-cycle pulses with no back-pressure; shift
  // qualifies serial_out every cycle it is high; done/error are one-cycle pulses.
  logic            start;
  logic [AW-1:0]   start_addr;
  logic [AW:0]     num_words;
  logic            sram_r_en;
  logic [AW-1:0]   sram_addr;
  logic            sram_data_valid;
  logic [COLS-1:0] sram_data_out;
  logic            serial_out;
  logic            shift;
  logic            busy;
  logic            done;
  logic            error;
  tx_state_t       dbg_state;

  modport master (
    input  start, start_addr, num_words, sram_data_valid, sram_data_out,
    output sram_r_en, sram_addr, serial_out, shift, busy, done, error, dbg_state
  );

  modport slave (
    output start, start_addr, num_words, sram_data_valid, sram_data_out,
    input  sram_r_en, sram_addr, serial_out, shift, busy, done, error, dbg_state
  );

endinterface

// File: rtl/sram_piso.sv
// Parallel-load, MSB-first left-shift register; each bit is held for BIT_CYCLES enabled cycles.
module sram_piso #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  output logic             dout,
  output logic             last
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int CW = $clog2(BIT_CYCLES + 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic             bit_end;

  always_comb begin
    shreg_d = shreg_q;
    bit_d   = bit_q;
    cyc_d   = cyc_q;
    bit_end = (cyc_q == CW'(BIT_CYCLES - 1));
    if (load) begin
      shreg_d = din;
      bit_d   = '0;
      cyc_d   = '0;
    end else if (en) begin
      if (bit_end) begin
        shreg_d = shreg_q << 1;
        bit_d   = bit_q + BW'(1);
        cyc_d   = '0;
      end else begin
        cyc_d = cyc_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
    end
  end

  assign dout = shreg_q[WIDTH-1];
  // High on the final enabled cycle of the final bit.
  assign last = en && bit_end && (bit_q == BW'(WIDTH - 1));

endmodule

// File: rtl/sram_serial_tx.sv
// Reads a run of consecutive SRAM rows and serializes each word MSB-first.
// Define SRAM_SERIAL_TX_PARITY_EN to append an even-parity bit after every word.
module sram_serial_tx
  import sram_pkg::*;
#(
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int BIT_CYCLES = 2,
  parameter int TIMEOUT    = 15
) (
  input logic             clk,
  input logic             rst,
  sram_serial_tx_if.master bus
);

  localparam int AW = $clog2(ROWS);
  localparam int WW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
`ifdef SRAM_SERIAL_TX_PARITY_EN
  localparam int NB = COLS + 1;
`else
  localparam int NB = COLS;
`endif

  tx_state_t     state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, addr_nxt;
  logic [AW-1:0] sram_addr_q, sram_addr_d;
  logic [WW-1:0] words_q, words_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          error_q, error_d;
  logic          piso_load, piso_en, piso_dout, piso_last;
  logic [NB-1:0] piso_din;

`ifdef SRAM_SERIAL_TX_PARITY_EN
  assign piso_din = {bus.sram_data_out, even_parity(64'(bus.sram_data_out))};
`else
  assign piso_din = bus.sram_data_out;
`endif

  // Explicit wrap so non-power-of-two depths still roll over at ROWS-1.
  assign addr_nxt = (addr_q == AW'(ROWS - 1)) ? '0 : addr_q + AW'(1);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    sram_addr_d = sram_addr_q;
    words_d     = words_q;
    tmo_d       = tmo_q;
    error_d     = 1'b0;
    piso_load   = 1'b0;
    piso_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          addr_d  = bus.start_addr;
          words_d = bus.num_words;
          if (bus.num_words == '0) begin
            state_d = ST_DONE;
          end else begin
            sram_addr_d = bus.start_addr;
            state_d     = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        tmo_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.sram_data_valid) begin
          piso_load = 1'b1;
          state_d   = ST_SHIFT;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_SHIFT: begin
        piso_en = 1'b1;
        if (piso_last) begin
          words_d = words_q - WW'(1);
          addr_d  = addr_nxt;
          if (words_q == WW'(1)) begin
            state_d = ST_DONE;
          end else begin
            sram_addr_d = addr_nxt;
            state_d     = ST_REQ;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      sram_addr_q <= '0;
      words_q     <= '0;
      tmo_q       <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      sram_addr_q <= sram_addr_d;
      words_q     <= words_d;
      tmo_q       <= tmo_d;
      error_q     <= error_d;
    end
  end

  sram_piso #(
    .WIDTH      (NB),
    .BIT_CYCLES (BIT_CYCLES)
  ) u_piso (
    .clk  (clk),
    .rst  (rst),
    .load (piso_load),
    .din  (piso_din),
    .en   (piso_en),
    .dout (piso_dout),
    .last (piso_last)
  );

  assign bus.sram_r_en  = (state_q == ST_REQ);
  assign bus.sram_addr  = sram_addr_q;
  assign bus.shift      = (state_q == ST_SHIFT);
  assign bus.serial_out = (state_q == ST_SHIFT) && piso_dout;
  assign bus.busy       = (state_q == ST_REQ) || (state_q == ST_WAIT) || (state_q == ST_SHIFT);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.error      = error_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: doc/sram_serial_tx.md
# sram_serial_tx

Read-side counterpart of the SRAM serial-load path. On a start request the block reads a run of consecutive SRAM rows through the macro's `r_en`/`addr`/`data_valid`/`data_out` port and serializes each word MSB-first onto a single-bit output, with a `shift` strobe paced exactly like the serial-load input. It sits between the SRAM top and the chip-level serial pins.

## Interface
- `ROWS`, 16: SRAM depth; address width `AW = $clog2(ROWS)`
- `COLS`, 8: word width, bits serialized per word
- `BIT_CYCLES`, 2: clock cycles each bit is held on `serial_out`; minimum 1
- `TIMEOUT`, 15: max cycles waited for `sram_data_valid` after a read request
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  request; sampled only in IDLE
- `start_addr`  in  AW  first row to read
- `num_words`  in  AW+1  rows to send; 0 allowed
- `sram_r_en`  out  1  one-cycle read pulse to SRAM
- `sram_addr`  out  AW  row address, valid while `sram_r_en` high and held until the next request
- `sram_data_valid`  in  1  SRAM read data valid, one-cycle pulse
- `sram_data_out`  in  COLS  SRAM read data
- `serial_out`  out  1  serial data, MSB first
- `shift`  out  1  high while `serial_out` carries a valid bit
- `busy`  out  1  high from the cycle after `start` is accepted until `done`
- `done`  out  1  one-cycle pulse at end of run
- `error`  out  1  one-cycle pulse on read timeout; run aborts

## Operation
- FSM states: IDLE, REQ, WAIT, SHIFT, DONE.
- IDLE: `start`=1 latches `start_addr` and `num_words`, then goes to REQ. If `num_words`=0, goes directly to DONE. `start` is ignored in every other state.
- REQ: drives `sram_r_en`=1 for exactly one cycle with the current address, then goes to WAIT with the timeout counter cleared.
- WAIT: on `sram_data_valid`=1, loads `sram_data_out` into the shift register and goes to SHIFT.
  - If `sram_data_valid` is high in the same cycle as REQ, it is ignored.
  - After `TIMEOUT` cycles in WAIT without valid: pulse `error`, go to IDLE. `done` is not pulsed.
- SHIFT: `shift`=1 and `serial_out`=shreg MSB.
  - A bit counter advances every `BIT_CYCLES` cycles, and the shift register shifts left.
  - After the last bit, the word counter decrements and the address increments modulo ROWS (ROWS-1 wraps to 0).
  - Then go to REQ if words remain, else to DONE.
- DONE: `done`=1 for one cycle, `busy`=0, then IDLE.
- `sram_data_valid` outside WAIT is ignored.
- `rst` mid-run: the next cycle is IDLE with all outputs 0. No partial word completes.

## Timing
- Reset value of every output is 0, including `sram_addr`.
- `start` accepted in cycle N: `busy`=1 and `sram_r_en`=1 in N+1.
- Valid in cycle M: the first bit appears on `serial_out`/`shift` in M+1.
- Each word occupies exactly COLS×BIT_CYCLES consecutive `shift`-high cycles (plus BIT_CYCLES for parity when enabled).
- Next `sram_r_en` comes in the cycle after the last bit of a word, so `shift` drops between words.
- `done` falls in the cycle after the last bit; `busy` is 0 in the same cycle as `done`.
- `error` and `done` are mutually exclusive and never coincide with `shift`.

## Configuration
- `SRAM_SERIAL_TX_PARITY_EN` defined: after the COLS data bits of each word, one extra bit equal to the even parity (XOR of the word) is sent for BIT_CYCLES cycles with `shift`=1.
- Not defined: exactly COLS bits per word, no parity logic.

## Structure
- Shared package `sram_pkg`:
  - `ROWS` and `COLS` defaults
  - FSM state enum `tx_state_t`
  - parity function `even_parity(word)`, also usable by the load-side checker
- Natural sub-module: `sram_piso`, a parallel-load/left-shift register with bit and cycle counters. Its ports are `load`, `din`, `en`, `dout`, `last`. The top holds the FSM, address/word counters and timeout.

## Test plan
- Reset → all outputs 0; after preload row1=8'b10011101, `start`, `start_addr`=1, `num_words`=1 → `sram_r_en` at N+1 with addr 1; `serial_out` = 1,0,0,1,1,1,0,1, each for 2 cycles with `shift`=1; `done` pulses one cycle later.
- `num_words`=3, `start_addr`=14, ROWS=16 → reads issued to addr 14, 15, 0 in order; 48 shift cycles; one `done`.
- `num_words`=0 → `done` at N+1, no `sram_r_en`, no `shift`.
- SRAM valid suppressed → `error` pulses TIMEOUT cycles after WAIT entry; no `done`; new `start` then works normally.
- `rst` asserted during the 4th bit → next cycle all outputs 0, state IDLE; `start` asserted mid-run is ignored with no extra read.
- With `SRAM_SERIAL_TX_PARITY_EN`, word 8'hA5 → 8 data bits then parity 0 (9×2 `shift` cycles); word 8'h01 → parity 1.
